// File: rtl/mm_timer_responder.sv
// Memory-mapped timer: prescaled 32-bit up-counter with compare match,
// one-shot/auto-reload modes, sticky W1C match flag and interrupt line.
// Optional input capture is built when MM_TIMER_CAPTURE_EN is defined.
module mm_timer_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0100,
  parameter int unsigned PRESC_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic        cap_in,
  output logic [31:0] RD,
  output logic        irq
);

  localparam logic [5:0] OffCtrl    = 6'd0;
  localparam logic [5:0] OffPresc   = 6'd1;
  localparam logic [5:0] OffCount   = 6'd2;
  localparam logic [5:0] OffCompare = 6'd3;
  localparam logic [5:0] OffStatus  = 6'd4;
  localparam logic [5:0] OffCapture = 6'd5;

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e                 state_q;
  logic [2:0]             ctrl_q;  // {IRQ_EN, AUTO_RELOAD, EN}
  logic [PRESC_WIDTH-1:0] presc_q;
  logic [PRESC_WIDTH-1:0] presc_cnt_q;
  logic [31:0]            count_q;
  logic [31:0]            compare_q;
  logic                   match_q;
  logic [31:0]            capture;

  logic       sel;
  logic [5:0] offset;
  logic       wr_ctrl, wr_presc, wr_count, wr_compare, wr_status;
  logic       tick, hit, enter_run;
  logic       unused_addr;

  assign sel         = (A[31:8] == BASE_ADDR[31:8]);
  assign offset      = A[7:2];
  assign unused_addr = ^A[1:0];

  // Decode bus writes into per-register strobes.
  always_comb begin
    wr_ctrl    = 1'b0;
    wr_presc   = 1'b0;
    wr_count   = 1'b0;
    wr_compare = 1'b0;
    wr_status  = 1'b0;
    if (we && sel) begin
      case (offset)
        OffCtrl:    wr_ctrl    = 1'b1;
        OffPresc:   wr_presc   = 1'b1;
        OffCount:   wr_count   = 1'b1;
        OffCompare: wr_compare = 1'b1;
        OffStatus:  wr_status  = 1'b1;
        default:    ;
      endcase
    end
  end

  assign tick = (state_q == StRun) && (presc_cnt_q == presc_q);
  // A software COUNT write on a tick suppresses match evaluation.
  assign hit  = tick && !wr_count && (count_q == compare_q);
  assign enter_run = (((state_q == StIdle) || (state_q == StHalt)) && wr_ctrl && WD[0]) ||
                     ((state_q == StHalt) && wr_count && ctrl_q[0]);

  // Timer state: registers, counter, match flag, FSM and prescaler.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      ctrl_q      <= '0;
      presc_q     <= '0;
      presc_cnt_q <= '0;
      count_q     <= '0;
      compare_q   <= 32'hFFFF_FFFF;
      match_q     <= 1'b0;
    end else begin
      if (wr_ctrl)    ctrl_q    <= WD[2:0];
      if (wr_presc)   presc_q   <= WD[PRESC_WIDTH-1:0];
      if (wr_compare) compare_q <= WD;

      if (wr_count) begin
        count_q <= WD;
      end else if (tick) begin
        if (count_q == compare_q) begin
          if (ctrl_q[1]) count_q <= '0;
        end else begin
          count_q <= count_q + 32'd1;
        end
      end

      // Set beats a simultaneous W1C so a fresh match is never lost.
      if (hit) begin
        match_q <= 1'b1;
      end else if (wr_status && WD[0]) begin
        match_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: if (wr_ctrl && WD[0]) state_q <= StRun;
        StRun: begin
          if (wr_ctrl && !WD[0]) begin
            state_q <= StIdle;
          end else if (hit && !ctrl_q[1]) begin
            state_q <= StHalt;
          end
        end
        StHalt: begin
          if (wr_ctrl) begin
            state_q <= WD[0] ? StRun : StIdle;
          end else if (wr_count && ctrl_q[0]) begin
            state_q <= StRun;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (enter_run || wr_presc || wr_count) begin
        presc_cnt_q <= '0;
      end else if (state_q == StRun) begin
        presc_cnt_q <= tick ? '0 : presc_cnt_q + PRESC_WIDTH'(1);
      end
    end
  end

`ifdef MM_TIMER_CAPTURE_EN
  logic        cap_meta_q, cap_sync_q, cap_prev_q;
  logic [31:0] capture_q;

  // Synchronize cap_in and latch the pre-update COUNT on its rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_meta_q <= 1'b0;
      cap_sync_q <= 1'b0;
      cap_prev_q <= 1'b0;
      capture_q  <= '0;
    end else begin
      cap_meta_q <= cap_in;
      cap_sync_q <= cap_meta_q;
      cap_prev_q <= cap_sync_q;
      if (cap_sync_q && !cap_prev_q) capture_q <= count_q;
    end
  end

  assign capture = capture_q;
`else
  logic unused_cap;

  assign unused_cap = cap_in;
  assign capture    = '0;
`endif

  // Combinational read mux; RD is zero unless a selected read is in progress.
  always_comb begin
    logic [31:0] presc_ext;
    presc_ext                    = '0;
    presc_ext[PRESC_WIDTH-1:0]   = presc_q;
    RD                           = '0;
    if (re && sel) begin
      case (offset)
        OffCtrl:    RD = {29'd0, ctrl_q};
        OffPresc:   RD = presc_ext;
        OffCount:   RD = count_q;
        OffCompare: RD = compare_q;
        OffStatus:  RD = {31'd0, match_q};
        OffCapture: RD = capture;
        default:    RD = '0;
      endcase
    end
  end

  assign irq = match_q & ctrl_q[2];

endmodule

// File: tb/tb_mm_timer_responder.sv
// Self-checking bench for mm_timer_responder: expected values are queued as
// stimulus is applied and popped when the corresponding bus read is made.
module tb_mm_timer_responder;

  localparam logic [31:0] Base     = 32'h1000_0100;
  localparam logic [31:0] ACtrl    = Base + 32'h00;
  localparam logic [31:0] APresc   = Base + 32'h04;
  localparam logic [31:0] ACount   = Base + 32'h08;
  localparam logic [31:0] ACompare = Base + 32'h0C;
  localparam logic [31:0] AStatus  = Base + 32'h10;
  localparam logic [31:0] ACapture = Base + 32'h14;
  localparam logic [31:0] AUnmap   = Base + 32'h18;
  localparam logic [31:0] AOther   = 32'h1000_0208;

  localparam logic [31:0] RstAddr [8] = '{ACtrl, APresc, ACount, ACompare,
                                          AStatus, ACapture, AUnmap, AOther};
  localparam logic [31:0] RstVal  [8] = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF,
                                          32'h0, 32'h0, 32'h0, 32'h0};

  logic        clk = 1'b0;
  logic        rst, re, we, cap_in, irq;
  logic [31:0] A, WD, RD;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] want;

  mm_timer_responder #(
    .BASE_ADDR  (Base),
    .PRESC_WIDTH(16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .re    (re),
    .we    (we),
    .A     (A),
    .WD    (WD),
    .cap_in(cap_in),
    .RD    (RD),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  // Tasks start and end just after a falling edge; a write spans one rising edge.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    A = addr; WD = data; we = 1'b1;
    @(negedge clk);
    we = 1'b0; WD = '0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    A = addr; re = 1'b1;
    #1;
    data = RD;
    re = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setup(input logic [31:0] p, input logic [31:0] c, input logic [31:0] n);
    bus_write(APresc, p);
    bus_write(ACompare, c);
    bus_write(ACount, n);
    bus_write(AStatus, 32'h1);
  endtask

  task automatic stop();
    bus_write(ACtrl, 32'h0);
    bus_write(AStatus, 32'h1);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(1);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(RstVal[i]);
      bus_read(RstAddr[i], rd);
      want = exp_q.pop_front();
      n_checks++;
      if (rd !== want) begin
        n_fail++;
        $display("FAIL reset_reg[%0d]: got %h, want %h", i, rd, want);
      end
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_irq: got %b, want 0", irq);
    end
    A = ACompare; re = 1'b0;
    #1;
    n_checks++;
    if (RD !== 32'h0) begin
      n_fail++;
      $display("FAIL rd_no_re: got %h, want 00000000", RD);
    end
    // Writes to an unmapped offset or another block must not land.
    idle(1);
    bus_write(AUnmap, 32'hFFFF_FFFF);
    bus_write(AOther, 32'h55);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    bus_read(ACtrl, rd);
    want = exp_q.pop_front();
    n_checks++;
    if (rd !== want) begin
      n_fail++;
      $display("FAIL unmapped_ctrl: got %h, want %h", rd, want);
    end
    bus_read(ACount, rd);
    want = exp_q.pop_front();
    n_checks++;
    if (rd !== want) begin
      n_fail++;
      $display("FAIL foreign_count: got %h, want %h", rd, want);
    end
    idle(1);
  endtask

  task automatic test_auto_reload();
    logic [31:0] rd;
    setup(32'd0, 32'd3, 32'd0);
    bus_write(APresc, 32'd0);
    bus_write(ACtrl, 32'h7);
    for (int j = 1; j <= 8; j++) begin
      exp_q.push_back(32'(j % 4));
      exp_q.push_back(32'(j >= 4));
      exp_q.push_back(32'(j >= 4));
      idle(1);
      bus_read(ACount, rd);
      want = exp_q.pop_front();
      n_checks++;
      if (rd !== want) begin
        n_fail++;
        $display("FAIL auto_count[%0d]: got %h, want %h", j, rd, want);
      end
      bus_read(AStatus, rd);
      want = exp_q.pop_front();
      n_checks++;
      if (rd !== want) begin
        n_fail++;
        $display("FAIL auto_match[%0d]: got %h, want %h", j, rd, want);
      end
      want = exp_q.pop_front();
      n_checks++;
      if ({31'd0, irq} !== want) begin
        n_fail++;
        $display("FAIL auto_irq[%0d]: got %b, want %0d", j, irq, want);
      end
    end
    stop();
  endtask

  task automatic test_one_shot();
    logic [31:0] rd;
    setup(32'd2, 32'd1, 32'd0);
    bus_write(ACtrl, 32'h1);
    for (int j = 1; j <= 8; j++) begin
      exp_q.push_back(32'(j >= 3));
      exp_q.push_back(32'(j >= 6));
      idle(1);
      bus_read(ACount, rd);
      want = exp_q.pop_front();
      n_checks++;
      if (rd !== want) begin
        n_fail++;
        $display("FAIL oneshot_count[%0d]: got %h, want %h", j, rd, want);
      end
      bus_read(AStatus, rd);
      want = exp_q.pop_front();
      n_checks++;
      if (rd !== want) begin
        n_fail++;
        $display("FAIL oneshot_match[%0d]: got %h, want %h", j, rd, want);
      end
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL oneshot_irq_masked: got %b, want 0", irq);
    end
    bus_write(AStatus, 32'h1);
    bus_write(ACount, 32'h0);
    for (int j = 1; j <= 6; j++) begin
      exp_q.push_back(32'(j >= 3));
      exp_q.push_back(32'(j == 6));
      idle(1);
      bus_read(ACount, rd);
      want = exp_q.pop_front();
      n_checks++;
      if (rd !== want) begin
        n_fail++;
        $display("FAIL resume_count[%0d]: got %h, want %h", j, rd, want);
      end
      bus_read(AStatus, rd);
      want = exp_q.pop_front();
      n_checks++;
      if (rd !== want) begin
        n_fail++;
        $display("FAIL resume_match[%0d]: got %h, want %h", j, rd, want);
      end
    end
    stop();
  endtask

  task automatic test_w1c_race();
    logic [31:0] rd;
    setup(32'd0, 32'd3, 32'd0);
    bus_write(ACtrl, 32'h7);
    idle(3);
    bus_write(AStatus, 32'h1);  // lands on the matching edge
    exp_q.push_back(32'h1);
    bus_read(AStatus, rd);
    want = exp_q.pop_front();
    n_checks++;
    if (rd !== want) begin
      n_fail++;
      $display("FAIL race_match: got %h, want %h", rd, want);
    end
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL race_irq: got %b, want 1", irq);
    end
    bus_write(AStatus, 32'h1);
    exp_q.push_back(32'h0);
    bus_read(AStatus, rd);
    want = exp_q.pop_front();
    n_checks++;
    if (rd !== want) begin
      n_fail++;
      $display("FAIL w1c_match: got %h, want %h", rd, want);
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL w1c_irq: got %b, want 0", irq);
    end
    stop();
  endtask

  task automatic test_wrap_precedence();
    logic [31:0] rd;
    setup(32'd0, 32'd5, 32'hFFFF_FFFE);
    bus_write(ACtrl, 32'h1);
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    for (int j = 1; j <= 3; j++) begin
      idle(1);
      bus_read(ACount, rd);
      want = exp_q.pop_front();
      n_checks++;
      if (rd !== want) begin
        n_fail++;
        $display("FAIL wrap_count[%0d]: got %h, want %h", j, rd, want);
      end
      bus_read(AStatus, rd);
      n_checks++;
      if (rd !== 32'h0) begin
        n_fail++;
        $display("FAIL wrap_flag[%0d]: got %h, want 00000000", j, rd);
      end
    end
    bus_write(ACount, 32'd100);  // coincides with a tick
    exp_q.push_back(32'd100);
    exp_q.push_back(32'd101);
    bus_read(ACount, rd);
    want = exp_q.pop_front();
    n_checks++;
    if (rd !== want) begin
      n_fail++;
      $display("FAIL write_wins: got %h, want %h", rd, want);
    end
    idle(1);
    bus_read(ACount, rd);
    want = exp_q.pop_front();
    n_checks++;
    if (rd !== want) begin
      n_fail++;
      $display("FAIL after_write: got %h, want %h", rd, want);
    end
    stop();
  endtask

  task automatic test_capture();
    logic [31:0] rd;
    logic [31:0] cap_exp;
`ifdef MM_TIMER_CAPTURE_EN
    cap_exp = 32'd11;
`else
    cap_exp = 32'd0;
`endif
    setup(32'd0, 32'hFFFF_FFFF, 32'd0);
    bus_write(ACtrl, 32'h1);
    idle(9);
    cap_in = 1'b1;
    idle(1);
    cap_in = 1'b0;
    idle(2);
    exp_q.push_back(cap_exp);
    exp_q.push_back(cap_exp);
    bus_read(ACapture, rd);
    want = exp_q.pop_front();
    n_checks++;
    if (rd !== want) begin
      n_fail++;
      $display("FAIL capture: got %h, want %h", rd, want);
    end
    idle(3);
    bus_read(ACapture, rd);
    want = exp_q.pop_front();
    n_checks++;
    if (rd !== want) begin
      n_fail++;
      $display("FAIL capture_hold: got %h, want %h", rd, want);
    end
    stop();
  endtask

  task automatic test_reset_midcount();
    logic [31:0] rd;
    setup(32'd0, 32'd3, 32'd0);
    bus_write(ACtrl, 32'h7);
    idle(5);
    #2;
    rst = 1'b0;
    #1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hFFFF_FFFF);
    bus_read(ACtrl, rd);
    want = exp_q.pop_front();
    n_checks++;
    if (rd !== want) begin
      n_fail++;
      $display("FAIL midrst_ctrl: got %h, want %h", rd, want);
    end
    bus_read(AStatus, rd);
    want = exp_q.pop_front();
    n_checks++;
    if (rd !== want) begin
      n_fail++;
      $display("FAIL midrst_status: got %h, want %h", rd, want);
    end
    bus_read(ACompare, rd);
    want = exp_q.pop_front();
    n_checks++;
    if (rd !== want) begin
      n_fail++;
      $display("FAIL midrst_compare: got %h, want %h", rd, want);
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_irq: got %b, want 0", irq);
    end
    @(negedge clk);
    rst = 1'b1;
    idle(3);
    exp_q.push_back(32'h0);
    bus_read(ACount, rd);
    want = exp_q.pop_front();
    n_checks++;
    if (rd !== want) begin
      n_fail++;
      $display("FAIL midrst_count: got %h, want %h", rd, want);
    end
  endtask

  initial begin
    rst = 1'b0; re = 1'b0; we = 1'b0; cap_in = 1'b0; A = '0; WD = '0;
    test_reset();
    test_auto_reload();
    test_one_shot();
    test_w1c_race();
    test_wrap_precedence();
    test_capture();
    test_reset_midcount();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
